// File: rtl/fetch_sequencer.sv
//==============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer. Owns the PC, addresses the
//               word-addressed instruction memory (combinational read) and
//               registers each fetched word into a valid/ready IF/ID slot.
//               Handles redirects, interrupt entry to IRQ_VECTOR and Eret.
//               Optional macro FETCH_PERF_EN enables the FetchCount and
//               SquashCount performance counters (tied to 0 otherwise).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstr,
  output logic [31:0] OutPC,
  output logic [31:0] OutPCPlus4,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  input  logic        Eret,
  input  logic        Irq,
  output logic        IrqAck,
  output logic [31:0] EPC,
  output logic        KernelMode,
  output logic [31:0] FetchCount,
  output logic [31:0] SquashCount
);

  // One post-reset bubble state, then run forever.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        run;
  logic        slot_free;
  logic        irq_pending;
  logic        do_redirect;
  logic        do_eret;
  logic        do_irq;
  logic        do_fetch;

  assign Address  = pc;
  assign pc_plus4 = pc + 32'd4;

  // Per-cycle action select, in strict priority order.
  assign run         = (state == ST_RUN);
  assign slot_free   = !OutValid || OutReady;
  assign irq_pending = Irq && !KernelMode;
  assign do_redirect = run && RedirectValid;
  assign do_eret     = run && !RedirectValid && Eret;
  assign do_irq      = run && !RedirectValid && !Eret && irq_pending && slot_free;
  assign do_fetch    = run && !RedirectValid && !Eret && !irq_pending && slot_free;

  // PC, output slot, interrupt state and sequencing state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      OutValid   <= 1'b0;
      OutInstr   <= 32'h0;
      OutPC      <= 32'h0;
      OutPCPlus4 <= 32'h0;
      IrqAck     <= 1'b0;
      EPC        <= 32'h0;
      KernelMode <= 1'b0;
    end else begin
      IrqAck <= 1'b0;
      if (state == ST_IDLE) begin
        state <= ST_RUN;
      end else if (do_redirect) begin
        // Target is forced to word alignment.
        pc       <= {RedirectTarget[31:2], 2'b00};
        OutValid <= 1'b0;
      end else if (do_eret) begin
        pc         <= EPC;
        KernelMode <= 1'b0;
        OutValid   <= 1'b0;
      end else if (do_irq) begin
        // The instruction at pc is not fetched; Eret reissues it from EPC.
        EPC        <= pc;
        pc         <= IRQ_VECTOR;
        KernelMode <= 1'b1;
        IrqAck     <= 1'b1;
        OutValid   <= 1'b0;
      end else if (do_fetch) begin
        OutInstr   <= Instruction;
        OutPC      <= pc;
        OutPCPlus4 <= pc_plus4;
        OutValid   <= 1'b1;
        pc         <= pc_plus4;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] squash_cnt;
  logic        squash;

  // A squash discards a slot that decode has not yet taken.
  assign squash = (do_redirect || do_eret) && OutValid && !OutReady;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt  <= 32'h0;
      squash_cnt <= 32'h0;
    end else begin
      if (do_fetch) fetch_cnt  <= fetch_cnt + 32'd1;
      if (squash)   squash_cnt <= squash_cnt + 32'd1;
    end
  end

  assign FetchCount  = fetch_cnt;
  assign SquashCount = squash_cnt;
`else
  assign FetchCount  = 32'h0;
  assign SquashCount = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//==============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstr;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        Eret;
  logic        Irq;
  logic        IrqAck;
  logic [31:0] EPC;
  logic        KernelMode;
  logic [31:0] FetchCount;
  logic [31:0] SquashCount;

  logic [31:0] mem [0:255];
  int errors;
  int checks;

`ifdef FETCH_PERF_EN
  localparam logic [31:0] EXP_FETCH2  = 32'd2;
  localparam logic [31:0] EXP_SQUASH1 = 32'd1;
`else
  localparam logic [31:0] EXP_FETCH2  = 32'd0;
  localparam logic [31:0] EXP_SQUASH1 = 32'd0;
`endif

  assign Instruction = mem[Address[9:2]];

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .Address       (Address),
    .Instruction   (Instruction),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .OutInstr      (OutInstr),
    .OutPC         (OutPC),
    .OutPCPlus4    (OutPCPlus4),
    .RedirectValid (RedirectValid),
    .RedirectTarget(RedirectTarget),
    .Eret          (Eret),
    .Irq           (Irq),
    .IrqAck        (IrqAck),
    .EPC           (EPC),
    .KernelMode    (KernelMode),
    .FetchCount    (FetchCount),
    .SquashCount   (SquashCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h2004_0003;
    mem[1] = 32'h0C00_0003;

    reset = 1'b0; OutReady = 1'b1; RedirectValid = 1'b0; RedirectTarget = 32'h0;
    Eret = 1'b0; Irq = 1'b0;
    tick(); tick();
    check("rst_addr",    Address,     32'h0);
    check("rst_valid",   {31'h0, OutValid}, 32'h0);
    check("rst_ack",     {31'h0, IrqAck},   32'h0);
    check("rst_kernel",  {31'h0, KernelMode}, 32'h0);
    check("rst_instr",   OutInstr,    32'h0);
    check("rst_epc",     EPC,         32'h0);
    check("rst_fcnt",    FetchCount,  32'h0);

    // Release reset: one IDLE bubble, first fetch on the second edge.
    reset = 1'b1;
    tick();
    check("idle_valid",  {31'h0, OutValid}, 32'h0);
    check("idle_addr",   Address,     32'h0);
    tick();
    check("f0_valid",    {31'h0, OutValid}, 32'h1);
    check("f0_instr",    OutInstr,    32'h2004_0003);
    check("f0_pc",       OutPC,       32'h0);
    check("f0_pc4",      OutPCPlus4,  32'h4);
    tick();
    check("f1_instr",    OutInstr,    32'h0C00_0003);
    check("f1_pc",       OutPC,       32'h4);
    check("f1_addr",     Address,     32'h8);
    check("f1_fcnt",     FetchCount,  EXP_FETCH2);

    // Stall three cycles: everything frozen.
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'h0, OutValid}, 32'h1);
      check("stall_instr", OutInstr,  32'h0C00_0003);
      check("stall_pc",    OutPC,     32'h4);
      check("stall_addr",  Address,   32'h8);
    end
    OutReady = 1'b1;
    tick();
    check("resume_pc",    OutPC,      32'h8);
    check("resume_instr", OutInstr,   32'hA500_0002);

    // Redirect while stalled: squash, bubble, then aligned target.
    OutReady = 1'b0; RedirectValid = 1'b1; RedirectTarget = 32'h0000_000E;
    tick();
    RedirectValid = 1'b0; OutReady = 1'b1;
    check("redir_bubble", {31'h0, OutValid}, 32'h0);
    check("redir_addr",   Address,    32'hC);
    tick();
    check("redir_valid",  {31'h0, OutValid}, 32'h1);
    check("redir_pc",     OutPC,      32'hC);
    check("redir_instr",  OutInstr,   32'hA500_0003);
    check("squash_cnt",   SquashCount, EXP_SQUASH1);

    // Move PC to 0x08 and take an interrupt there.
    RedirectValid = 1'b1; RedirectTarget = 32'h8;
    tick();
    RedirectValid = 1'b0;
    check("pre_irq_addr", Address,    32'h8);
    Irq = 1'b1;
    tick();
    check("irq_ack",      {31'h0, IrqAck}, 32'h1);
    check("irq_epc",      EPC,        32'h8);
    check("irq_kernel",   {31'h0, KernelMode}, 32'h1);
    check("irq_bubble",   {31'h0, OutValid}, 32'h0);
    check("irq_addr",     Address,    32'h100);
    tick();
    check("irq_ack_low",  {31'h0, IrqAck}, 32'h0);
    check("vec_pc",       OutPC,      32'h100);
    check("vec_instr",    OutInstr,   32'hA500_0040);
    tick();
    check("irq2_ignored_ack", {31'h0, IrqAck}, 32'h0);
    check("irq2_ignored_epc", EPC,    32'h8);
    check("irq2_pc",      OutPC,      32'h104);

    // Return from interrupt.
    Irq = 1'b0; Eret = 1'b1;
    tick();
    Eret = 1'b0;
    check("eret_bubble",  {31'h0, OutValid}, 32'h0);
    check("eret_kernel",  {31'h0, KernelMode}, 32'h0);
    tick();
    check("eret_pc",      OutPC,      32'h8);
    check("eret_valid",   {31'h0, OutValid}, 32'h1);

    // Re-enter kernel mode, then redirect and Eret together.
    Irq = 1'b1;
    tick();
    Irq = 1'b0;
    check("irq3_epc",     EPC,        32'hC);
    check("irq3_kernel",  {31'h0, KernelMode}, 32'h1);
    RedirectValid = 1'b1; RedirectTarget = 32'h40; Eret = 1'b1;
    tick();
    RedirectValid = 1'b0; Eret = 1'b0;
    check("re_kernel",    {31'h0, KernelMode}, 32'h1);
    check("re_bubble",    {31'h0, OutValid}, 32'h0);
    tick();
    check("re_pc",        OutPC,      32'h40);
    check("re_kernel2",   {31'h0, KernelMode}, 32'h1);

    // PC wrap at the top of the address space.
    RedirectValid = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
    tick();
    RedirectValid = 1'b0;
    tick();
    check("wrap_pc",      OutPC,      32'hFFFF_FFFC);
    check("wrap_pc4",     OutPCPlus4, 32'h0);
    check("wrap_addr",    Address,    32'h0);
    check("wrap_instr",   OutInstr,   32'hA500_00FF);

    // Fetch 0x2C so PC sits at 0x30, then reset asynchronously.
    RedirectValid = 1'b1; RedirectTarget = 32'h2C;
    tick();
    RedirectValid = 1'b0;
    tick();
    check("pre_rst_addr", Address,    32'h30);
    #2;
    reset = 1'b0;
    #1;
    check("arst_addr",    Address,    32'h0);
    check("arst_valid",   {31'h0, OutValid}, 32'h0);
    check("arst_kernel",  {31'h0, KernelMode}, 32'h0);
    check("arst_epc",     EPC,        32'h0);
    check("arst_pc",      OutPC,      32'h0);
    check("arst_instr",   OutInstr,   32'h0);
    check("arst_pc4",     OutPCPlus4, 32'h0);
    check("arst_scnt",    SquashCount, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rerun_idle",   {31'h0, OutValid}, 32'h0);
    tick();
    check("rerun_pc",     OutPC,      32'h0);
    check("rerun_instr",  OutInstr,   32'h2004_0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Sequences the word-addressed instruction memory (combinational read, word index = Address[9:2]).
- Owns the program counter, drives the memory address, and registers each fetched word into a valid/ready IF/ID output slot.
- Applies downstream redirects (branch, jump, jal, jr), interrupt entry to a fixed vector, and return from interrupt.
- Sits between the instruction memory and the decode stage of the CPU.

## Interface
- RESET_PC, 32'h00000000, PC loaded on reset
- IRQ_VECTOR, 32'h00000100, interrupt entry PC
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- Address  out  32  instruction memory address (= PC register)
- Instruction  in  32  memory read data, combinational from Address
- OutValid  out  1  output slot holds a fetched instruction
- OutReady  in  1  decode accepts slot this cycle
- OutInstr  out  32  fetched instruction word
- OutPC  out  32  PC of OutInstr
- OutPCPlus4  out  32  OutPC + 4
- RedirectValid  in  1  redirect PC this cycle
- RedirectTarget  in  32  redirect destination
- Eret  in  1  return to saved EPC, leave interrupt mode
- Irq  in  1  level interrupt request
- IrqAck  out  1  one-cycle pulse on interrupt entry
- EPC  out  32  saved return PC
- KernelMode  out  1  interrupt mode flag
- FetchCount  out  32  instructions fetched (see Configuration)
- SquashCount  out  32  valid slots discarded (see Configuration)

## Operation
- States: IDLE (one post-reset bubble) and RUN. IDLE -> RUN unconditionally. RUN holds until reset.
- A fetch slot is free when OutValid==0 or OutReady==1.
- In RUN, per cycle, highest priority first:
  1. RedirectValid:
     - PC <= {RedirectTarget[31:2],2'b00}.
     - OutValid <= 0.
     - Squash when OutValid==1 && OutReady==0.
  2. Eret (ignored if RedirectValid is also high):
     - PC <= EPC, KernelMode <= 0, OutValid <= 0, same squash rule.
  3. Irq && !KernelMode && slot free:
     - EPC <= PC, PC <= IRQ_VECTOR, KernelMode <= 1, IrqAck <= 1.
     - OutValid <= 0.
     - The instruction at PC is not fetched; it reissues after Eret.
  4. Slot free (fetch):
     - OutInstr <= Instruction, OutPC <= PC, OutPCPlus4 <= PC+4, OutValid <= 1.
     - PC <= PC+4.
  5. Otherwise: hold PC and all output registers.
- Irq while KernelMode==1 is ignored. Irq is level-sensitive and is re-sampled after Eret.
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
- In IDLE, Address = RESET_PC and no fetch occurs.

## Timing
- Reset values:
  - PC = RESET_PC.
  - OutValid = 0, IrqAck = 0, KernelMode = 0.
  - OutInstr, OutPC, OutPCPlus4, EPC, FetchCount, SquashCount = 0.
  - State = IDLE.
- The first fetch happens in the second rising edge after reset deasserts. OutValid rises after that edge.
- Fetch latency: the word at Address is presented on OutInstr one cycle later. Throughput is one word per cycle while OutReady==1.
- Redirect, Eret, and IRQ each cost one bubble cycle (OutValid==0). The target word appears on the following cycle.
- Stall: with OutValid==1 && OutReady==0, the outputs and PC are frozen and stable.
- IrqAck is high for exactly one cycle, the cycle after entry.
- Reset asserted mid-operation clears all state immediately (asynchronous). Any in-flight slot is lost and is not counted.

## Configuration
- FETCH_PERF_EN defined:
  - FetchCount increments on every fetch.
  - SquashCount increments on every squash.
  - Both wrap at 2^32.
- FETCH_PERF_EN undefined: FetchCount and SquashCount are tied to 0, no counter registers exist, and the ports remain.

## Test plan
- Memory programmed with addi 0x20040003 at word 0 and jal 0x0C000003 at word 1; OutReady=1, release reset. Required: OutValid first high 2 cycles after release, OutInstr=0x20040003 with OutPC=0, then 0x0C000003 with OutPC=4.
- Hold OutReady=0 for 3 cycles while OutValid=1. Required: OutInstr, OutPC, and Address unchanged. Then raise OutReady: the next word follows with no loss.
- RedirectValid with RedirectTarget=0x0000000E while the slot is stalled. Required: OutValid 0 for one cycle, then OutPC=0x0000000C, SquashCount=1 (with FETCH_PERF_EN).
- Irq=1 at PC=0x08. Required: IrqAck pulse, EPC=0x08, KernelMode=1, then OutPC=0x100. A second Irq is ignored. Eret then yields OutPC=0x08 and KernelMode=0.
- RedirectValid (target 0x40) and Eret in the same cycle. Required: next OutPC=0x40, KernelMode stays 1.
- Assert reset mid-stream at PC=0x30. Required: all outputs zero immediately and Address=RESET_PC. Fetch resumes from 0 after IDLE.
